pipe_hazard_ctrl: RTL and testbench

Central pipeline sequencer for the 5-stage rv32i core. Each cycle it drives the load/flush/bubble enables of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It detects load-use hazards, resolves taken-branch redirects (including redirects that arrive while an instruction fetch is outstanding), and freezes the pipe on data-memory stalls. It also keeps stall and flush performance counters.

---
 rtl/rv32i_types.sv | 13 +
 rtl/load_use_detect.sv | 24 ++
 rtl/pipe_hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared rv32i core types: register index, data word and pipeline-control FSM states.
package rv32i_types;

  typedef logic [4:0]  rv32i_reg;
  typedef logic [31:0] rv32i_word;

  // KILL: a redirect is pending behind an outstanding fetch whose response must be discarded.
  typedef enum logic {
    RUN,
    KILL
  } pipe_ctrl_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Flags an ID instruction that reads the destination of a load currently in EX.
module load_use_detect
  import rv32i_types::*;
(
  input  rv32i_reg id_rs1,
  input  rv32i_reg id_rs2,
  input  logic     id_uses_rs1,
  input  logic     id_uses_rs2,
  input  rv32i_reg ex_rd,
  input  logic     ex_mem_read,
  output logic     lu
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
    rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);
    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    lu      = ex_mem_read && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage rv32i core: register enables, redirects, stalls and
// performance counters.
module pipe_hazard_ctrl
  import rv32i_types::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  rv32i_reg             id_rs1,
  input  rv32i_reg             id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  rv32i_reg             ex_rd,
  input  logic                 ex_mem_read,
  input  logic                 ex_br_taken,
  input  rv32i_word            ex_br_target,
  input  logic                 imem_resp,
  input  logic                 dmem_access,
  input  logic                 dmem_resp,
  output logic                 load_pc,
  output logic                 pc_sel,
  output rv32i_word            redirect_target,
  output logic                 load_if_id,
  output logic                 flush_if_id,
  output logic                 load_id_ex,
  output logic                 bubble_id_ex,
  output logic                 load_ex_mem,
  output logic                 load_mem_wb,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] flush_events
);

  pipe_ctrl_state_t state_q, state_d;
  rv32i_word        saved_target_q, saved_target_d;
  logic             lu;
  logic             dstall;

  load_use_detect u_load_use_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .lu          (lu)
  );

  assign dstall = dmem_access && !dmem_resp;

  always_comb begin
    state_d         = state_q;
    saved_target_d  = saved_target_q;
    load_pc         = 1'b0;
    pc_sel          = 1'b0;
    redirect_target = '0;
    load_if_id      = 1'b0;
    flush_if_id     = 1'b0;
    load_id_ex      = 1'b0;
    bubble_id_ex    = 1'b0;
    load_ex_mem     = 1'b0;
    load_mem_wb     = 1'b0;

    if (!rst) begin
      redirect_target = (state_q == KILL) ? saved_target_q : ex_br_target;

      // A dmem stall freezes everything, including a branch waiting in EX.
      if (!dstall) begin
        load_ex_mem = 1'b1;
        load_mem_wb = 1'b1;
        unique case (state_q)
          RUN: begin
            if (ex_br_taken) begin
              load_if_id   = 1'b1;
              flush_if_id  = 1'b1;
              load_id_ex   = 1'b1;
              bubble_id_ex = 1'b1;
              if (imem_resp) begin
                load_pc = 1'b1;
                pc_sel  = 1'b1;
              end else begin
                // Fetch address must stay stable; remember where to go once it returns.
                saved_target_d = ex_br_target;
                state_d        = KILL;
              end
            end else if (!imem_resp || lu) begin
              load_id_ex   = 1'b1;
              bubble_id_ex = 1'b1;
            end else begin
              load_pc    = 1'b1;
              load_if_id = 1'b1;
              load_id_ex = 1'b1;
            end
          end
          KILL: begin
            load_id_ex   = 1'b1;
            bubble_id_ex = 1'b1;
            if (imem_resp) begin
              load_pc     = 1'b1;
              pc_sel      = 1'b1;
              load_if_id  = 1'b1;
              flush_if_id = 1'b1;
              state_d     = RUN;
            end
          end
          default: state_d = RUN;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= RUN;
      saved_target_q <= '0;
      stall_cycles   <= '0;
      flush_events   <= '0;
    end else begin
      state_q        <= state_d;
      saved_target_q <= saved_target_d;
      if (!load_pc) begin
        stall_cycles <= stall_cycles + CNT_WIDTH'(1);
      end
      if (flush_if_id) begin
        flush_events <= flush_events + CNT_WIDTH'(1);
      end
    end
  end

  // EX holds only bubbles while a redirect is pending, so no branch can resolve there.
  kill_no_branch : assert property (@(posedge clk) disable iff (rst)
    (state_q == KILL) |-> !ex_br_taken);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios followed by constrained-random
// traffic, expected responses come from a behavioural model of the sequencing rules.
module tb_pipe_hazard_ctrl;
  import rv32i_types::*;

  localparam int unsigned CW = 4;

  typedef struct packed {
    logic        rst;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        uses1;
    logic        uses2;
    logic [4:0]  ex_rd;
    logic        mem_read;
    logic        br;
    logic [31:0] target;
    logic        imem;
    logic        dacc;
    logic        dresp;
  } stim_t;

  typedef struct packed {
    logic          load_pc;
    logic          pc_sel;
    logic [31:0]   redirect_target;
    logic          load_if_id;
    logic          flush_if_id;
    logic          load_id_ex;
    logic          bubble_id_ex;
    logic          load_ex_mem;
    logic          load_mem_wb;
    logic [CW-1:0] stall_cycles;
    logic [CW-1:0] flush_events;
  } out_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          id_uses_rs1, id_uses_rs2, ex_mem_read, ex_br_taken;
  logic [31:0]   ex_br_target;
  logic          imem_resp, dmem_access, dmem_resp;
  logic          load_pc, pc_sel, load_if_id, flush_if_id, load_id_ex, bubble_id_ex;
  logic          load_ex_mem, load_mem_wb;
  logic [31:0]   redirect_target;
  logic [CW-1:0] stall_cycles, flush_events;

  pipe_hazard_ctrl #(.CNT_WIDTH(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .ex_rd           (ex_rd),
    .ex_mem_read     (ex_mem_read),
    .ex_br_taken     (ex_br_taken),
    .ex_br_target    (ex_br_target),
    .imem_resp       (imem_resp),
    .dmem_access     (dmem_access),
    .dmem_resp       (dmem_resp),
    .load_pc         (load_pc),
    .pc_sel          (pc_sel),
    .redirect_target (redirect_target),
    .load_if_id      (load_if_id),
    .flush_if_id     (flush_if_id),
    .load_id_ex      (load_id_ex),
    .bubble_id_ex    (bubble_id_ex),
    .load_ex_mem     (load_ex_mem),
    .load_mem_wb     (load_mem_wb),
    .stall_cycles    (stall_cycles),
    .flush_events    (flush_events)
  );

  always #5 clk = ~clk;

  out_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   step_no = 0;

  // Reference model: pending-redirect flag, its target, and the two counters.
  bit            m_kill;
  logic [31:0]   m_saved;
  logic [CW-1:0] m_stall, m_flush;

  function automatic out_t expect_out(input stim_t s);
    out_t o;
    bit   hazard, frozen;
    o = '0;
    o.stall_cycles = m_stall;
    o.flush_events = m_flush;
    if (s.rst) return o;
    o.redirect_target = m_kill ? m_saved : s.target;
    hazard = s.mem_read && s.ex_rd != 0 &&
             ((s.uses1 && s.rs1 == s.ex_rd) || (s.uses2 && s.rs2 == s.ex_rd));
    frozen = s.dacc && !s.dresp;
    if (frozen) return o;
    o.load_ex_mem = 1'b1;
    o.load_mem_wb = 1'b1;
    o.load_id_ex  = 1'b1;
    if (m_kill) begin
      o.bubble_id_ex = 1'b1;
      if (s.imem) begin
        o.load_pc = 1'b1; o.pc_sel = 1'b1; o.load_if_id = 1'b1; o.flush_if_id = 1'b1;
      end
    end else if (s.br) begin
      o.bubble_id_ex = 1'b1; o.load_if_id = 1'b1; o.flush_if_id = 1'b1;
      if (s.imem) begin
        o.load_pc = 1'b1; o.pc_sel = 1'b1;
      end
    end else if (!s.imem || hazard) begin
      o.bubble_id_ex = 1'b1;
    end else begin
      o.load_pc = 1'b1; o.load_if_id = 1'b1;
    end
    return o;
  endfunction

  task automatic step(input stim_t s);
    out_t e;
    @(posedge clk);
    #1;
    rst = s.rst; id_rs1 = s.rs1; id_rs2 = s.rs2; id_uses_rs1 = s.uses1; id_uses_rs2 = s.uses2;
    ex_rd = s.ex_rd; ex_mem_read = s.mem_read; ex_br_taken = s.br; ex_br_target = s.target;
    imem_resp = s.imem; dmem_access = s.dacc; dmem_resp = s.dresp;
    if (s.rst) begin
      m_kill = 0; m_saved = '0; m_stall = '0; m_flush = '0;
    end
    e = expect_out(s);
    exp_q.push_back(e);
    if (!s.rst) begin
      if (!e.load_pc) m_stall = m_stall + 1'b1;
      if (e.flush_if_id) m_flush = m_flush + 1'b1;
      if (!(s.dacc && !s.dresp)) begin
        if (!m_kill && s.br && !s.imem) begin
          m_kill = 1; m_saved = s.target;
        end else if (m_kill && s.imem) begin
          m_kill = 0;
        end
      end
    end
  endtask

  function automatic stim_t nop();
    stim_t s;
    s = '0;
    s.imem = 1'b1;
    return s;
  endfunction

  // Monitor: outputs are combinational and valid every cycle; compare at the falling edge.
  initial begin
    out_t e, g;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        step_no++;
        g = '{load_pc, pc_sel, redirect_target, load_if_id, flush_if_id, load_id_ex,
              bubble_id_ex, load_ex_mem, load_mem_wb, stall_cycles, flush_events};
        checks++;
        if (g[2*CW +: 40] === e[2*CW +: 40]) passes++;
        else $display("FAIL ctrl step %0d: got pc=%b sel=%b tgt=%h ifid=%b fl=%b idex=%b bub=%b exm=%b mwb=%b, required pc=%b sel=%b tgt=%h ifid=%b fl=%b idex=%b bub=%b exm=%b mwb=%b",
                      step_no, g.load_pc, g.pc_sel, g.redirect_target, g.load_if_id,
                      g.flush_if_id, g.load_id_ex, g.bubble_id_ex, g.load_ex_mem, g.load_mem_wb,
                      e.load_pc, e.pc_sel, e.redirect_target, e.load_if_id, e.flush_if_id,
                      e.load_id_ex, e.bubble_id_ex, e.load_ex_mem, e.load_mem_wb);
        checks++;
        if (g.stall_cycles === e.stall_cycles && g.flush_events === e.flush_events) passes++;
        else $display("FAIL counters step %0d: got stall=%0d flush=%0d, required stall=%0d flush=%0d",
                      step_no, g.stall_cycles, g.flush_events, e.stall_cycles, e.flush_events);
      end
    end
  end

  initial begin
    stim_t s;
    s = nop();
    s.rst = 1'b1;
    rst = 1'b1;
    step(s);
    step(s);

    // Load-use hazard, then the same with rd=x0.
    s = nop(); s.mem_read = 1; s.ex_rd = 5; s.rs1 = 5; s.uses1 = 1;
    step(s);
    s.ex_rd = 0;
    step(s);
    step(nop());

    // Taken branch with fetch ready.
    s = nop(); s.br = 1; s.target = 32'h60;
    step(s);

    // Taken branch with fetch outstanding for four cycles.
    s = nop(); s.br = 1; s.target = 32'h80; s.imem = 0;
    step(s);
    s = nop(); s.imem = 0;
    repeat (3) step(s);
    step(nop());

    // Data-memory stall holding a branch in EX.
    s = nop(); s.br = 1; s.target = 32'h40; s.dacc = 1; s.dresp = 0;
    repeat (4) step(s);
    s.dresp = 1;
    step(s);

    // Load-use and branch together: branch wins.
    s = nop(); s.mem_read = 1; s.ex_rd = 5; s.rs1 = 5; s.uses1 = 1; s.br = 1;
    s.target = 32'h100;
    step(s);

    // Reset while a redirect is pending.
    s = nop(); s.br = 1; s.target = 32'h20; s.imem = 0;
    step(s);
    s = nop(); s.imem = 0;
    step(s);
    s = nop(); s.rst = 1;
    step(s);
    step(s);
    step(nop());

    // Constrained-random traffic; small register set makes hazards frequent.
    for (int i = 0; i < 2000; i++) begin
      s.rst      = ($urandom_range(0, 149) == 0);
      s.rs1      = 5'($urandom_range(0, 3));
      s.rs2      = 5'($urandom_range(0, 3));
      s.uses1    = 1'($urandom);
      s.uses2    = 1'($urandom);
      s.ex_rd    = 5'($urandom_range(0, 3));
      s.mem_read = ($urandom_range(0, 2) == 0);
      s.br       = !m_kill && ($urandom_range(0, 4) == 0);
      s.target   = $urandom & 32'hffff_fffc;
      s.imem     = ($urandom_range(0, 9) < 7);
      s.dacc     = ($urandom_range(0, 9) < 3);
      s.dresp    = 1'($urandom);
      step(s);
    end

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL drain: got %0d pending responses, required 0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
